// File: rtl/bulk_line_memory_controller.sv
// Whole-line request endpoint: serialises one cache-line read or write into
// single-word accesses on a synchronous SRAM and returns a one-cycle response.
module bulk_line_memory_controller #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int LINE_SIZE   = 8,
    parameter int SRAM_ADDR_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          req_write,
    input  logic [LINE_SIZE*DATA_W-1:0]   req_wdata,
    input  logic [LINE_SIZE*DATA_W/8-1:0] req_wstrb,
    output logic                          resp_valid,
    output logic [LINE_SIZE*DATA_W-1:0]   resp_rdata,
    output logic                          sram_en,
    output logic                          sram_we,
    output logic [SRAM_ADDR_W-1:0]        sram_addr,
    output logic [DATA_W-1:0]             sram_wdata,
    output logic [DATA_W/8-1:0]           sram_wstrb,
    input  logic [DATA_W-1:0]             sram_rdata
);
    localparam int STRB_W   = DATA_W / 8;
    localparam int BYTE_OFF = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(LINE_SIZE);

    typedef enum logic [1:0] { IDLE, BURST, DRAIN, RESP } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       cnt;
    logic [SRAM_ADDR_W-1:0] base;
    logic                   wr_flag;
    logic [DATA_W-1:0]      wdata_q  [LINE_SIZE];
    logic [STRB_W-1:0]      wstrb_q  [LINE_SIZE];
    logic [DATA_W-1:0]      line_buf [LINE_SIZE];
    logic                   cap_valid;
    logic [IDX_W-1:0]       cap_idx;
    logic                   last_word;
    logic [SRAM_ADDR_W-1:0] req_base;
    logic                   unused_addr;

    // Line-aligned word address; bits above the SRAM range are dropped, so the
    // base wraps and the in-line index can never carry out of the line.
    assign req_base    = {req_addr[BYTE_OFF+SRAM_ADDR_W-1:BYTE_OFF+IDX_W], {IDX_W{1'b0}}};
    assign unused_addr = ^req_addr;
    assign last_word   = (cnt == IDX_W'(LINE_SIZE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            base      <= '0;
            wr_flag   <= 1'b0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            // NOTE: the line buffers are flops rather than a RAM macro, so they
            // take the async reset; resp_rdata reads zero after an aborted burst.
            for (int i = 0; i < LINE_SIZE; i++) begin
                wdata_q[i]  <= '0;
                wstrb_q[i]  <= '0;
                line_buf[i] <= '0;
            end
        end else begin
            // NOTE: all state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state     <= state_nxt;
            cap_valid <= (state == BURST) && !wr_flag;
            cap_idx   <= cnt;
            if (cap_valid) begin
                line_buf[cap_idx] <= sram_rdata;
            end
            if (state == IDLE && req_valid) begin
                base    <= req_base;
                wr_flag <= req_write;
                cnt     <= '0;
                for (int i = 0; i < LINE_SIZE; i++) begin
                    wdata_q[i] <= req_wdata[i*DATA_W +: DATA_W];
                    wstrb_q[i] <= req_wstrb[i*STRB_W +: STRB_W];
                end
            end else if (state == BURST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        sram_en    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wstrb = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = BURST;
            end
            BURST: begin
                sram_en   = 1'b1;
                sram_we   = wr_flag;
                sram_addr = {base[SRAM_ADDR_W-1:IDX_W], cnt};
                if (wr_flag) begin
                    sram_wdata = wdata_q[cnt];
                    sram_wstrb = wstrb_q[cnt];
                end
                if (last_word) state_nxt = wr_flag ? RESP : DRAIN;
            end
            DRAIN: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp_rdata = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            resp_rdata[i*DATA_W +: DATA_W] = line_buf[i];
        end
    end

endmodule

// File: tb/tb_bulk_line_memory_controller.sv
// Scoreboard bench for bulk_line_memory_controller: SRAM model, reference
// memory, expected accesses/responses queued at accept and checked on output.
module tb_bulk_line_memory_controller;
    localparam int DW = 64;
    localparam int LS = 8;
    localparam int LW = LS * DW;
    localparam int SW = LS * DW / 8;

    typedef logic [LW-1:0] line_t;
    typedef logic [SW-1:0] strb_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } acc_t;

    typedef struct {
        int    cyc;
        line_t rdata;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, resp_valid;
    logic [63:0] req_addr;
    line_t       req_wdata, resp_rdata;
    strb_t       req_wstrb;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr;
    logic [63:0] sram_wdata, sram_rdata;
    logic [7:0]  sram_wstrb;

    logic        req_valid_w, req_ready_w, resp_valid_w;
    logic [63:0] req_addr_w;
    line_t       resp_rdata_w;
    logic        sram_en_w, sram_we_w;
    logic [9:0]  sram_addr_w;
    logic [63:0] sram_wdata_w, sram_rdata_w;
    logic [7:0]  sram_wstrb_w;

    logic [63:0] mem     [65536];
    logic [63:0] ref_mem [65536];
    logic [63:0] mem_w   [1024];

    acc_t  acc_q[$];
    rsp_t  rsp_q[$];
    line_t last_line;
    int    last_resp_cyc;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bulk_line_memory_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata)
    );

    bulk_line_memory_controller #(.SRAM_ADDR_W(10)) dut_w (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_w), .req_ready(req_ready_w), .req_addr(req_addr_w),
        .req_write(1'b0), .req_wdata('0), .req_wstrb('0),
        .resp_valid(resp_valid_w), .resp_rdata(resp_rdata_w),
        .sram_en(sram_en_w), .sram_we(sram_we_w), .sram_addr(sram_addr_w),
        .sram_wdata(sram_wdata_w), .sram_wstrb(sram_wstrb_w), .sram_rdata(sram_rdata_w)
    );

    // Synchronous SRAM models: read data appears the cycle after the access.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (sram_wstrb[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    always @(posedge clk) begin
        if (sram_en_w && !sram_we_w) sram_rdata_w <= mem_w[sram_addr_w];
    end

    task automatic check(input string tag, input line_t got, input line_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] line_base(input logic [63:0] a);
        logic [63:0] w;
        w      = a >> 3;
        w[2:0] = 3'b0;
        return w[15:0];
    endfunction

    // Output monitor for the main instance.
    always @(negedge clk) begin : monitor
        acc_t a;
        rsp_t r;
        if (rst) begin
            if (sram_en) begin
                check("busy_ready", req_ready, 0);
                if (acc_q.size() == 0) begin
                    check("spurious_access", sram_en, 0);
                end else begin
                    a = acc_q.pop_front();
                    check("acc_cycle", cyc, a.cyc);
                    check("acc_addr", sram_addr, a.addr);
                    check("acc_we", sram_we, a.we);
                    if (a.we) begin
                        check("acc_wdata", sram_wdata, a.wdata);
                        check("acc_wstrb", sram_wstrb, a.wstrb);
                    end
                end
            end
            if (resp_valid) begin
                check("resp_ready", req_ready, 0);
                if (rsp_q.size() == 0) begin
                    check("spurious_resp", resp_valid, 0);
                end else begin
                    r = rsp_q.pop_front();
                    check("resp_cycle", cyc, r.cyc);
                    check("resp_rdata", resp_rdata, r.rdata);
                end
            end
        end
    end

    // Drives a request (req_valid left high) and queues its expectations at accept.
    task automatic issue(input logic wr, input logic [63:0] addr, input line_t wd,
                         input strb_t ws, input int expect_at);
        logic        accepted;
        int          c0;
        logic [15:0] base;
        acc_t        a;
        rsp_t        r;
        line_t       exp_line;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        req_valid = 1'b1;
        accepted  = 1'b0;
        for (int w = 0; w < 64 && !accepted; w++) begin
            @(negedge clk);
            accepted = req_ready;
        end
        if (!accepted) begin
            check("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        c0 = cyc;
        if (expect_at >= 0) check("accept_cycle", c0, expect_at);
        base = line_base(addr);
        exp_line = '0;
        for (int i = 0; i < LS; i++) begin
            a.cyc   = c0 + 1 + i;
            a.we    = wr;
            a.addr  = base | 16'(i);
            a.wdata = wd[i*64 +: 64];
            a.wstrb = ws[i*8 +: 8];
            acc_q.push_back(a);
            if (wr) begin
                for (int b = 0; b < 8; b++)
                    if (ws[i*8+b]) ref_mem[a.addr][b*8 +: 8] = wd[i*64 + b*8 +: 8];
            end else begin
                exp_line[i*64 +: 64] = ref_mem[a.addr];
            end
        end
        r.cyc = c0 + LS + (wr ? 1 : 2);
        if (wr) begin
            r.rdata = last_line;
        end else begin
            r.rdata   = exp_line;
            last_line = exp_line;
        end
        rsp_q.push_back(r);
        last_resp_cyc = r.cyc;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int w = 0; w < 64 && (acc_q.size() != 0 || rsp_q.size() != 0); w++) @(negedge clk);
        check("drain_timeout", acc_q.size() + rsp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_line(output line_t wd, output strb_t ws);
        for (int i = 0; i < LS; i++) begin
            wd[i*64 +: 64] = {$urandom, $urandom};
            ws[i*8 +: 8]   = 8'($urandom);
        end
    endtask

    initial begin
        line_t       wd, exp_w;
        strb_t       ws;
        logic [15:0] w_base;

        rst = 1'b0;
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        req_valid_w = 0; req_addr_w = '0;
        sram_rdata = '0; sram_rdata_w = '0;
        for (int n = 0; n < 65536; n++) begin
            mem[n]     = 64'(n);
            ref_mem[n] = 64'(n);
        end
        for (int n = 0; n < 1024; n++) mem_w[n] = 64'hC0DE_0000_0000_0000 | 64'(n);
        last_line = '0;

        #3;
        check("rst_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_en", sram_en, 0);
        check("rst_we", sram_we, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_wstrb", sram_wstrb, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Read of a misaligned address inside line 0x200
        issue(0, 64'h1038, '0, '0, -1);
        req_valid = 0;
        drain();

        // Write 0xA0+i with a half strobe on word 3, then read back
        for (int i = 0; i < LS; i++) wd[i*64 +: 64] = 64'hA0 + 64'(i);
        ws = '1;
        ws[3*8 +: 8] = 8'h0F;
        issue(1, 64'h2000, wd, ws, -1);
        req_valid = 0;
        drain();
        issue(0, 64'h2000, '0, '0, -1);
        req_valid = 0;
        drain();

        // Random bytes and strobes, including one word with no strobes
        rand_line(wd, ws);
        ws[5*8 +: 8] = 8'h00;
        issue(1, 64'h2008, wd, ws, -1);
        req_valid = 0;
        drain();
        issue(0, 64'h2000, '0, '0, -1);
        req_valid = 0;
        drain();

        // req_valid held high, alternating read/write back-to-back
        issue(0, 64'h1038, '0, '0, -1);
        rand_line(wd, ws);
        issue(1, 64'h3000, wd, ws, last_resp_cyc + 1);
        issue(0, 64'h3010, '0, '0, last_resp_cyc + 1);
        rand_line(wd, ws);
        issue(1, 64'h1000, wd, '1, last_resp_cyc + 1);
        issue(0, 64'h1000, '0, '0, last_resp_cyc + 1);
        req_valid = 0;
        drain();

        // Narrow SRAM instance: base 0x400 wraps to 0x000
        w_base = line_base(64'h2000) & 16'h03FF;
        for (int i = 0; i < LS; i++) exp_w[i*64 +: 64] = mem_w[w_base + 16'(i)];
        req_addr_w  = 64'h2000;
        req_valid_w = 1'b1;
        @(negedge clk);
        check("wrap_ready", req_ready_w, 1);
        @(posedge clk); #1;
        req_valid_w = 1'b0;
        for (int k = 1; k <= LS + 3; k++) begin
            @(negedge clk);
            check("wrap_en", sram_en_w, (k <= LS));
            if (k <= LS) check("wrap_addr", sram_addr_w, w_base + 16'(k - 1));
            check("wrap_resp", resp_valid_w, (k == LS + 2));
            if (k == LS + 2) check("wrap_rdata", resp_rdata_w, exp_w);
        end
        @(posedge clk); #1;

        // Asynchronous reset in cycle 4 of a write burst: words 0..2 land, rest do not
        rand_line(wd, ws);
        issue(1, 64'h5000, wd, '1, -1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        acc_q.delete();
        rsp_q.delete();
        #1;
        check("abort_en", sram_en, 0);
        check("abort_we", sram_we, 0);
        check("abort_addr", sram_addr, 0);
        check("abort_wdata", sram_wdata, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_ready", req_ready, 1);
        check("abort_rdata", resp_rdata, 0);
        req_valid = 0;
        for (int n = 0; n < 65536; n++) ref_mem[n] = 64'(n);
        for (int n = 0; n < 65536; n++) ref_mem[n] = mem[n] === 64'bx ? ref_mem[n] : ref_mem[n];
        for (int i = 0; i < LS; i++) ref_mem[16'h0A00 + 16'(i)] = (i < 3) ? wd[i*64 +: 64] : 64'h0A00 + 64'(i);
        last_line = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);
        check("no_resp_after_rst", resp_valid, 0);
        @(posedge clk); #1;
        rand_line(wd, ws);
        issue(1, 64'h6000, wd, ws, -1);
        req_valid = 0;
        drain();
        issue(0, 64'h5000, '0, '0, -1);
        req_valid = 0;
        drain();
        issue(0, 64'h6000, '0, '0, -1);
        req_valid = 0;
        drain();

        check("queues_empty", acc_q.size() + rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
